// File: rtl/blake_msg_sched.sv
// BLAKE-512 message/constant scheduler: streams sigma-permuted words and constants, LANES G per beat.
// Optional feature: define BLAKE_MSG_PAD_EN for a 10-word input block padded to an 80-byte message.
module blake_msg_sched #(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned LANES  = 1,
`ifdef BLAKE_MSG_PAD_EN
  localparam int unsigned MSG_W = 640
`else
  localparam int unsigned MSG_W = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MSG_W-1:0]      in_msg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*LANES-1:0]   out_m0,
  output logic [64*LANES-1:0]   out_m1,
  output logic [64*LANES-1:0]   out_k0,
  output logic [64*LANES-1:0]   out_k1,
  output logic [4:0]            out_round,
  output logic [2:0]            out_step,
  output logic                  out_last
);
  localparam int unsigned STEPS = 8 / LANES;
  localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned LW    = $clog2(LANES);
  localparam int unsigned NW    = MSG_W / 64;

  if (ROUNDS < 1 || ROUNDS > 20) begin : g_bad_rounds
    $error("blake_msg_sched: ROUNDS must be in 1..20");
  end
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("blake_msg_sched: LANES must be 1, 2, 4 or 8");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  function automatic logic [63:0] sigma_row(input logic [3:0] r);
    logic [63:0] v;
    v = 64'h0123456789ABCDEF;
    case (r)
      4'd1:    v = 64'hEA489FD61C02B753;
      4'd2:    v = 64'hB8C052FDAE367194;
      4'd3:    v = 64'h7931DCBE265A40F8;
      4'd4:    v = 64'h905724AFE1BC683D;
      4'd5:    v = 64'h2C6A0B834D75FE19;
      4'd6:    v = 64'hC51FED4A0763928B;
      4'd7:    v = 64'hDB7EC13950F4862A;
      4'd8:    v = 64'h6FE9B308C2D714A5;
      4'd9:    v = 64'hA2847615FB9E3CD0;
      default: v = 64'h0123456789ABCDEF;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] cval(input logic [3:0] i);
    logic [63:0] v;
    v = '0;
    unique case (i)
      4'd0:  v = 64'h243F6A8885A308D3;
      4'd1:  v = 64'h13198A2E03707344;
      4'd2:  v = 64'hA4093822299F31D0;
      4'd3:  v = 64'h082EFA98EC4E6C89;
      4'd4:  v = 64'h452821E638D01377;
      4'd5:  v = 64'hBE5466CF34E90C6C;
      4'd6:  v = 64'hC0AC29B7C97C50DD;
      4'd7:  v = 64'h3F84D5B5B5470917;
      4'd8:  v = 64'h9216D5D98979FB1B;
      4'd9:  v = 64'hD1310BA698DFB5AC;
      4'd10: v = 64'h2FFD72DBD01ADFB7;
      4'd11: v = 64'hB8E1AFED6A267E96;
      4'd12: v = 64'hBA7C9045F12C7F99;
      4'd13: v = 64'h24A19947B3916CF7;
      4'd14: v = 64'h0801F2E2858EFC16;
      4'd15: v = 64'h636920D871574E69;
    endcase
    return v;
  endfunction

  state_e          st_q, st_d;
  logic [SW-1:0]   step_q, step_d;
  logic [4:0]      round_q, round_d;
  logic [3:0]      sig_q, sig_d;
  logic [63:0]     w_q [NW];
  logic [63:0]     words [16];
  logic            run, load, step_wrap, round_wrap;
  logic [2:0]      base, g;
  logic [3:0]      i0, i1;
  logic [63:0]     row;

  assign run        = (st_q == StRun);
  assign in_ready   = (st_q == StIdle) && !rst;
  assign load       = in_valid && in_ready;
  assign step_wrap  = (step_q == SW'(STEPS - 1));
  assign round_wrap = (round_q == 5'(ROUNDS - 1));

  always_comb begin
    st_d    = st_q;
    step_d  = step_q;
    round_d = round_q;
    sig_d   = sig_q;
    unique case (st_q)
      StIdle: begin
        if (load) begin
          st_d    = StRun;
          step_d  = '0;
          round_d = '0;
          sig_d   = '0;
        end
      end
      StRun: begin
        if (out_ready) begin
          if (!step_wrap) begin
            step_d = step_q + SW'(1);
          end else begin
            step_d = '0;
            if (round_wrap) begin
              st_d    = StIdle;
              round_d = '0;
              sig_d   = '0;
            end else begin
              round_d = round_q + 5'd1;
              // sigma row tracks round mod 10 without a divider
              sig_d   = (sig_q == 4'd9) ? 4'd0 : sig_q + 4'd1;
            end
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StIdle;
      step_q  <= '0;
      round_q <= '0;
      sig_q   <= '0;
    end else begin
      st_q    <= st_d;
      step_q  <= step_d;
      round_q <= round_d;
      sig_q   <= sig_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NW; i++) w_q[i] <= in_msg[64*(NW-1-i) +: 64];
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) words[i] = '0;
    for (int i = 0; i < NW; i++) words[i] = w_q[i];
`ifdef BLAKE_MSG_PAD_EN
    words[10] = 64'h8000000000000000;
    words[13] = 64'h0000000000000001;
    words[15] = 64'h0000000000000280;
`endif
  end

  always_comb begin
    out_m0 = '0;
    out_m1 = '0;
    out_k0 = '0;
    out_k1 = '0;
    g      = '0;
    i0     = '0;
    i1     = '0;
    base   = 3'(step_q) << LW;
    row    = sigma_row(sig_q);
    if (run) begin
      for (int j = 0; j < LANES; j++) begin
        g  = base + 3'(j);
        // hex digit d (MSB first) lives at bits [(15-d)*4 +: 4]
        i0 = row[{~g, 1'b1, 2'b00} +: 4];
        i1 = row[{~g, 1'b0, 2'b00} +: 4];
        out_m0[64*j +: 64] = words[i0];
        out_m1[64*j +: 64] = words[i1];
        out_k0[64*j +: 64] = cval(i0);
        out_k1[64*j +: 64] = cval(i1);
      end
    end
  end

  assign out_valid = run;
  assign out_round = run ? round_q : '0;
  assign out_step  = run ? base : '0;
  assign out_last  = run && round_wrap && step_wrap;

endmodule

// File: tb/tb_blake_msg_sched.sv
// Scoreboard bench for blake_msg_sched: default instance plus a LANES=4, ROUNDS=14 instance.
`timescale 1ns/1ps
module tb_blake_msg_sched;
`ifdef BLAKE_MSG_PAD_EN
  localparam int MSG_W = 640;
`else
  localparam int MSG_W = 1024;
`endif
  localparam int NW = MSG_W / 64;

  typedef struct packed {
    logic         valid;
    logic         rdy;
    logic         last;
    logic [4:0]   round;
    logic [2:0]   step;
    logic [255:0] m0;
    logic [255:0] m1;
    logic [255:0] k0;
    logic [255:0] k1;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [MSG_W-1:0] in_msg;
  logic             in_valid0, in_valid1, out_ready0, out_ready1;
  logic             in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
  logic [63:0]      m0_0, m1_0, k0_0, k1_0;
  logic [255:0]     m0_1, m1_1, k0_1, k1_1;
  logic [4:0]       round0, round1;
  logic [2:0]       step0, step1;

  blake_msg_sched dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_msg(in_msg),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_m0(m0_0), .out_m1(m1_0),
    .out_k0(k0_0), .out_k1(k1_0), .out_round(round0), .out_step(step0), .out_last(out_last0)
  );

  blake_msg_sched #(.ROUNDS(14), .LANES(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_msg(in_msg),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_m0(m0_1), .out_m1(m1_1),
    .out_k0(k0_1), .out_k1(k1_1), .out_round(round1), .out_step(step1), .out_last(out_last1)
  );

  int sigma [10][16] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
    '{14, 10, 4, 8, 9, 15, 13, 6, 1, 12, 0, 2, 11, 7, 5, 3},
    '{11, 8, 12, 0, 5, 2, 15, 13, 10, 14, 3, 6, 7, 1, 9, 4},
    '{7, 9, 3, 1, 13, 12, 11, 14, 2, 6, 5, 10, 4, 0, 15, 8},
    '{9, 0, 5, 7, 2, 4, 10, 15, 14, 1, 11, 12, 6, 8, 3, 13},
    '{2, 12, 6, 10, 0, 11, 8, 3, 4, 13, 7, 5, 15, 14, 1, 9},
    '{12, 5, 1, 15, 14, 13, 4, 10, 0, 7, 6, 3, 9, 2, 8, 11},
    '{13, 11, 7, 14, 12, 1, 3, 9, 5, 0, 15, 4, 8, 6, 2, 10},
    '{6, 15, 14, 9, 11, 3, 0, 8, 12, 2, 13, 7, 1, 4, 10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5, 15, 11, 9, 14, 3, 12, 13, 0}
  };
  logic [63:0] cst [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };

  logic [63:0] mw [16];
  obs_t        sb [$];
  obs_t        cap [$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic sample(input int sel, output obs_t o);
    o = '0;
    if (sel == 0) begin
      o.valid = out_valid0; o.rdy = in_ready0; o.last = out_last0;
      o.round = round0; o.step = step0;
      o.m0 = 256'(m0_0); o.m1 = 256'(m1_0); o.k0 = 256'(k0_0); o.k1 = 256'(k1_0);
    end else begin
      o.valid = out_valid1; o.rdy = in_ready1; o.last = out_last1;
      o.round = round1; o.step = step1;
      o.m0 = m0_1; o.m1 = m1_1; o.k0 = k0_1; o.k1 = k1_1;
    end
  endtask

  task automatic set_ready(input int sel, input logic v);
    if (sel == 0) out_ready0 = v;
    else out_ready1 = v;
  endtask

  function automatic obs_t model_beat(input int lanes, input int rounds, input int r, input int s);
    obs_t e;
    e = '0;
    e.valid = 1'b1;
    e.round = 5'(r);
    e.step  = 3'(s * lanes);
    e.last  = (r == rounds - 1) && (s == 8 / lanes - 1);
    for (int j = 0; j < lanes; j++) begin
      int gi = s * lanes + j;
      int a  = sigma[r % 10][2 * gi];
      int b  = sigma[r % 10][2 * gi + 1];
      e.m0[64*j +: 64] = mw[a];
      e.m1[64*j +: 64] = mw[b];
      e.k0[64*j +: 64] = cst[a];
      e.k1[64*j +: 64] = cst[b];
    end
    return e;
  endfunction

  // Drives one block at the current negedge; seed 0 gives the 0x0101..*(i+1) pattern.
  task automatic load_block(input int sel, input int seed);
    logic [63:0] tw [16];
    obs_t o;
    int lanes, rounds;
    lanes  = (sel == 0) ? 1 : 4;
    rounds = (sel == 0) ? 16 : 14;
    for (int i = 0; i < 16; i++) begin
      if (seed == 0) tw[i] = 64'h0101010101010101 * 64'(i + 1);
      else tw[i] = {$urandom, $urandom};
      mw[i] = (i < NW) ? tw[i] : 64'h0;
    end
`ifdef BLAKE_MSG_PAD_EN
    mw[10] = 64'h8000000000000000;
    mw[13] = 64'h0000000000000001;
    mw[15] = 64'h0000000000000280;
`endif
    for (int i = 0; i < NW; i++) in_msg[64*(NW-1-i) +: 64] = tw[i];
    sample(sel, o);
    n_cmp++;
    if (o.rdy !== 1'b1) begin
      n_err++;
      $display("FAIL in_ready_before_load sel=%0d: got %b, expected 1", sel, o.rdy);
    end
    if (sel == 0) in_valid0 = 1'b1;
    else in_valid1 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    sample(sel, o);
    n_cmp++;
    if (o.valid !== 1'b1 || o.rdy !== 1'b0) begin
      n_err++;
      $display("FAIL beat0_latency sel=%0d: got valid=%b in_ready=%b, expected valid=1 in_ready=0",
               sel, o.valid, o.rdy);
    end
    for (int r = 0; r < rounds; r++)
      for (int s = 0; s < 8 / lanes; s++) sb.push_back(model_beat(lanes, rounds, r, s));
  endtask

  // Consumes n beats against the scoreboard; optionally stalls after sampling beat stall_at.
  task automatic consume(input int sel, input int n, input int stall_at, input int stall_len);
    obs_t o, e, h;
    set_ready(sel, 1'b1);
    cap.delete();
    for (int b = 0; b < n; b++) begin
      sample(sel, o);
      for (int w = 0; w < 4 && o.valid !== 1'b1; w++) begin
        @(negedge clk);
        sample(sel, o);
      end
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty sel=%0d beat=%0d: got empty queue, expected an entry", sel, b);
        return;
      end
      e = sb.pop_front();
      if (o !== e) begin
        n_err++;
        $display("FAIL beat sel=%0d b=%0d: got v=%b l=%b r=%0d s=%0d m0=%h m1=%h k0=%h k1=%h, expected v=%b l=%b r=%0d s=%0d m0=%h m1=%h k0=%h k1=%h",
                 sel, b, o.valid, o.last, o.round, o.step, o.m0[63:0], o.m1[63:0], o.k0[63:0],
                 o.k1[63:0], e.valid, e.last, e.round, e.step, e.m0[63:0], e.m1[63:0],
                 e.k0[63:0], e.k1[63:0]);
      end
      cap.push_back(o);
      if (b == stall_at) begin
        set_ready(sel, 1'b0);
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          sample(sel, h);
          n_cmp++;
          if (h !== e) begin
            n_err++;
            $display("FAIL stall_hold cycle=%0d: got r=%0d s=%0d v=%b m0=%h, expected r=%0d s=%0d v=1 m0=%h",
                     k, h.round, h.step, h.valid, h.m0[63:0], e.round, e.step, e.m0[63:0]);
          end
        end
        set_ready(sel, 1'b1);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input int sel, input string name);
    obs_t o, e;
    e = '0;
    e.rdy = 1'b1;
    sample(sel, o);
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL %s sel=%0d: got valid=%b in_ready=%b last=%b r=%0d s=%0d m0=%h, expected valid=0 in_ready=1 zeros",
               name, sel, o.valid, o.rdy, o.last, o.round, o.step, o.m0[63:0]);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready0 = 1'b0; out_ready1 = 1'b0;
    in_msg = '0;
    repeat (3) @(negedge clk);
    for (int sel = 0; sel < 2; sel++) begin
      sample(sel, o);
      n_cmp++;
      if (o !== '0) begin
        n_err++;
        $display("FAIL reset_state sel=%0d: got valid=%b in_ready=%b r=%0d s=%0d m0=%h, expected all 0",
                 sel, o.valid, o.rdy, o.round, o.step, o.m0[63:0]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    check_idle(0, "reset_release");
    check_idle(1, "reset_release");
  endtask

  task automatic test_stream();
    int nlast;
    load_block(0, 0);
    consume(0, 128, -1, 0);
    n_cmp++;
    if (cap.size() != 128 || sb.size() != 0) begin
      n_err++;
      $display("FAIL beat_count: got %0d beats (%0d left), expected 128 (0 left)", cap.size(), sb.size());
      return;
    end
    for (int b = 0; b < 81; b += 80) begin
      n_cmp++;
      if (cap[b].m0[63:0] !== 64'h0101010101010101 || cap[b].m1[63:0] !== 64'h0202020202020202 ||
          cap[b].k0[63:0] !== 64'h243F6A8885A308D3 || cap[b].k1[63:0] !== 64'h13198A2E03707344) begin
        n_err++;
        $display("FAIL beat%0d_data: got m0=%h m1=%h k0=%h k1=%h, expected 0101.. 0202.. 243F6A8885A308D3 13198A2E03707344",
                 b, cap[b].m0[63:0], cap[b].m1[63:0], cap[b].k0[63:0], cap[b].k1[63:0]);
      end
    end
    n_cmp++;
    if (cap[0].round !== 5'd0 || cap[0].step !== 3'd0 || cap[80].round !== 5'd10) begin
      n_err++;
      $display("FAIL beat_round_step: got b0 r=%0d s=%0d b80 r=%0d, expected 0 0 10",
               cap[0].round, cap[0].step, cap[80].round);
    end
    n_cmp++;
`ifdef BLAKE_MSG_PAD_EN
    if (cap[8].m0[63:0] !== 64'h0 || cap[8].m1[63:0] !== 64'h8000000000000000 ||
`else
    if (cap[8].m0[63:0] !== 64'h0F0F0F0F0F0F0F0F || cap[8].m1[63:0] !== 64'h0B0B0B0B0B0B0B0B ||
`endif
        cap[8].k0[63:0] !== 64'h0801F2E2858EFC16 || cap[8].k1[63:0] !== 64'h2FFD72DBD01ADFB7) begin
      n_err++;
      $display("FAIL beat8_data: got m0=%h m1=%h k0=%h k1=%h, expected w14 w10 0801F2E2858EFC16 2FFD72DBD01ADFB7",
               cap[8].m0[63:0], cap[8].m1[63:0], cap[8].k0[63:0], cap[8].k1[63:0]);
    end
    nlast = 0;
    for (int b = 0; b < 128; b++) if (cap[b].last === 1'b1) nlast++;
    n_cmp++;
    if (nlast != 1 || cap[127].last !== 1'b1) begin
      n_err++;
      $display("FAIL last_flag: got %0d high (beat127=%b), expected 1 high on beat 127", nlast, cap[127].last);
    end
    check_idle(0, "idle_after_last");
  endtask

  task automatic test_backpressure();
    load_block(0, 1);
    consume(0, 128, 3, 5);
    n_cmp++;
    if (cap.size() != 128 || cap[4].step !== 3'd4 || cap[4].round !== 5'd0) begin
      n_err++;
      $display("FAIL after_stall: got %0d beats, beat4 step=%0d, expected 128 beats, step 4", cap.size(),
               (cap.size() > 4) ? cap[4].step : 3'd0);
    end
    check_idle(0, "idle_after_stall_block");
  endtask

  task automatic test_back_to_back();
    load_block(0, 2);
    consume(0, 128, -1, 0);
    check_idle(0, "idle_b2b_first");
    load_block(0, 3);
    consume(0, 128, -1, 0);
    check_idle(0, "idle_b2b_second");
  endtask

  task automatic test_lanes4();
    load_block(1, 0);
    consume(1, 28, -1, 0);
    n_cmp++;
    if (cap.size() != 28 || cap[1].m0[63:0] !== 64'h0909090909090909 ||
        cap[1].k1[63:0] !== 64'hD1310BA698DFB5AC || cap[1].step !== 3'd4 || cap[27].last !== 1'b1) begin
      n_err++;
      $display("FAIL lanes4_beat1: got %0d beats m0=%h k1=%h step=%0d, expected 28 0909090909090909 D1310BA698DFB5AC 4",
               cap.size(), cap[1].m0[63:0], cap[1].k1[63:0], cap[1].step);
    end
    check_idle(1, "lanes4_idle");
  endtask

  task automatic test_reset_mid();
    obs_t o;
    load_block(0, 4);
    consume(0, 40, -1, 0);
    rst = 1'b1;
    @(negedge clk);
    sample(0, o);
    n_cmp++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got valid=%b in_ready=%b r=%0d s=%0d, expected all 0",
               o.valid, o.rdy, o.round, o.step);
    end
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_idle(0, "mid_reset_release");
    load_block(0, 0);
    consume(0, 128, -1, 0);
    n_cmp++;
    if (cap.size() == 0 || cap[0].round !== 5'd0 || cap[0].step !== 3'd0) begin
      n_err++;
      $display("FAIL restart_beat0: got %0d beats r=%0d s=%0d, expected round 0 step 0", cap.size(),
               (cap.size() > 0) ? cap[0].round : 5'd31, (cap.size() > 0) ? cap[0].step : 3'd7);
    end
    check_idle(0, "idle_after_restart");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_lanes4();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within 500us");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/blake_msg_sched.md
# blake_msg_sched

Parametrised BLAKE-512 message/constant scheduler. It sits between the header loader and the round core. It accepts one message block over a valid/ready handshake and stores it. It then streams the sigma-permuted message words and round constants for every G-function of every round, LANES G-functions per beat, under downstream backpressure.

## Interface
Parameters:
- ROUNDS, 16, number of rounds to schedule; legal 1..20, otherwise elaboration error.
- LANES, 1, G-functions served per beat; legal 1, 2, 4, 8, otherwise elaboration error.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, reset, synchronous, active-high.
- in_valid, input, 1, message block offered.
- in_ready, output, 1, block accepted when in_valid & in_ready.
- in_msg, input, MSG_W, block. MSG_W = 640 with BLAKE_MSG_PAD_EN, otherwise 1024. Word 0 sits in the MSBs.
- out_valid, output, 1, beat available.
- out_ready, input, 1, beat consumed when out_valid & out_ready.
- out_m0, output, 64*LANES, m[sigma(2g)] per lane.
- out_m1, output, 64*LANES, m[sigma(2g+1)] per lane.
- out_k0, output, 64*LANES, c[sigma(2g)] per lane.
- out_k1, output, 64*LANES, c[sigma(2g+1)] per lane.
- out_round, output, 5, round number of the current beat, 0..ROUNDS-1.
- out_step, output, 3, G index of lane 0.
- out_last, output, 1, high on the final beat of the block.

## Operation
- States: IDLE and RUN.
- In IDLE, in_ready = 1. On a handshake:
  - latch in_msg into the 16x64 word register;
  - clear the beat counter;
  - go to RUN.
- In RUN, in_ready = 0 and out_valid = 1. in_valid is ignored.
- Beat counter: step field STEPS = 8/LANES wide, plus a round field.
  - On an out handshake, step increments.
  - When step wraps, round increments.
  - The handshake on the beat with round = ROUNDS-1 and step = STEPS-1 is the last beat; the block returns to IDLE.
- Beats per block = ROUNDS*STEPS.
- Lane j of a beat uses G index g = step*LANES + j. Lane 0 occupies the LSBs of each packed output.
- Sigma row = round mod 10. idx0 = hex digit 2g of the row and idx1 = hex digit 2g+1, MSB digit first.
- Sigma rows 0..9:
  - 0123456789ABCDEF
  - EA489FD61C02B753
  - B8C052FDAE367194
  - 7931DCBE265A40F8
  - 905724AFE1BC683D
  - 2C6A0B834D75FE19
  - C51FED4A0763928B
  - DB7EC13950F4862A
  - 6FE9B308C2D714A5
  - A2847615FB9E3CD0
- Constants c0..c15 are the BLAKE-512 pi constants: c0 = 243F6A8885A308D3, c1 = 13198A2E03707344, …, c10 = 2FFD72DBD01ADFB7, c14 = 0801F2E2858EFC16, c15 = 636920D871574E69.
- Round modulo is computed without a divider: a separate 0..9 sigma counter wraps alongside the round field.
- out_last = out_valid & (round = ROUNDS-1) & (step = STEPS-1).

## Timing
- Reset values:
  - state = IDLE, counters = 0, word register = 0;
  - out_valid = 0, out_last = 0, out_round = 0, out_step = 0, all data outputs = 0;
  - in_ready = 0 while rst is high and 1 from the first cycle after rst is released.
- Latency: in handshake at cycle t; beat 0 is valid at t+1.
- Throughput: one beat per cycle while out_ready = 1.
- Data outputs are driven from registered state only. There is no combinational path from out_ready or in_valid to any output.
- Data outputs are forced to 0 whenever out_valid = 0.
- Backpressure: while out_valid = 1 and out_ready = 0, all outputs hold stable.
- After the last handshake at cycle t:
  - out_valid = 0 and in_ready = 1 at t+1;
  - the next block's beat 0 can be valid at t+2 at the earliest.
- rst mid-block: at the next edge all state returns to reset values. No further beats are issued and the partial block is discarded.

## Configuration
- BLAKE_MSG_PAD_EN defined:
  - in_msg is 640 bits and loads words 0..9;
  - words 10..15 are constants for an 80-byte message: w10 = 8000000000000000, w11 = 0, w12 = 0, w13 = 0000000000000001, w14 = 0, w15 = 0000000000000280.
- Undefined:
  - in_msg is 1024 bits and all 16 words are loaded from the port;
  - no padding logic is present.

## Test plan
1. Default parameters, pad on, word i = 0x0101010101010101*(i+1). Beat 0 → out_m0 = 0101010101010101, out_m1 = 0202020202020202, out_k0 = 243F6A8885A308D3, out_k1 = 13198A2E03707344, out_round = 0, out_step = 0.
2. Same block, beat 8 (round 1, step 0; idx0 = E, idx1 = A) → out_m0 = 0, out_m1 = 8000000000000000, out_k0 = 0801F2E2858EFC16, out_k1 = 2FFD72DBD01ADFB7.
3. Full run with out_ready held at 1 → exactly 128 beats. Beat 80 (round 10) matches beat 0 data. out_last is high only on beat 127. in_ready = 1 the cycle after.
4. out_ready low for 5 cycles at beat 3 → all outputs stable. Beat 4 follows with out_step = 4, and no beat is skipped.
5. LANES = 4, ROUNDS = 14 → 28 beats. Beat 1, lane 0 (G4) uses idx 8/9: out_m0[63:0] = word 8, out_k1[63:0] = D1310BA698DFB5AC.
6. rst pulsed at beat 40 → out_valid = 0 the next cycle, in_ready = 1 after release. A new block starts at out_round = 0, out_step = 0.
